// File: rtl/clock_set_controller_if.sv
// Button inputs and time-counter control outputs of the clock set controller.
// The driver side (buttons in, controls out) is the master; the controller is the slave.
interface clock_set_controller_if;
   logic       switch;
   logic       add;
   logic       deduct;
   logic [1:0] mode;
   logic       run_en;
   logic       inc;
   logic       dec;
   logic       blink;
   logic       timeout;

   modport master (
      output switch, add, deduct,
      input  mode, run_en, inc, dec, blink, timeout
   );

   modport slave (
      input  switch, add, deduct,
      output mode, run_en, inc, dec, blink, timeout
   );
endinterface

// File: rtl/clock_set_controller.sv
// Front-end sequencer for the time-keeping datapath: synchronises and debounces
// the three active-low buttons, runs the IDLE/SET_SEC/SET_MIN/SET_HOUR mode
// machine, and drives inc/dec strobes (with auto-repeat), run_en, blink and an
// inactivity timeout.
module clock_set_controller #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 16,
   parameter int REPEAT_RATE     = 4,
   parameter int TIMEOUT_CYCLES  = 256,
   parameter int BLINK_HALF      = 8
) (
   input logic                   clk,
   input logic                   rst,
   clock_set_controller_if.slave bus
);

   localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RP_W    = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
   localparam int TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int BL_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RP_W-1:0] DLY_LAST  = RP_W'(REPEAT_DELAY - 1);
   localparam logic [RP_W-1:0] RATE_LAST = RP_W'(REPEAT_RATE - 1);
   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [BL_W-1:0] BL_LAST   = BL_W'(BLINK_HALF - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SET_SEC  = 2'd1,
      SET_MIN  = 2'd2,
      SET_HOUR = 2'd3
   } mode_t;

   // bit 0 = switch, bit 1 = add, bit 2 = deduct
   logic [2:0] btn_raw;
   logic [2:0] press;

   assign btn_raw = {bus.deduct, bus.add, bus.switch};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_btn
         logic            s1_reg;
         logic            s2_reg;
         logic            deb_reg;
         logic            press_reg;
         logic [DB_W-1:0] cnt_reg;

         // Two-flop synchroniser, debounce counter and registered press (1->0) event.
         always_ff @(posedge clk) begin
            if (rst) begin
               s1_reg    <= 1'b1;
               s2_reg    <= 1'b1;
               deb_reg   <= 1'b1;
               press_reg <= 1'b0;
               cnt_reg   <= '0;
            end else begin
               s1_reg    <= btn_raw[gi];
               s2_reg    <= s1_reg;
               press_reg <= 1'b0;
               if (s2_reg == deb_reg) begin
                  // any sample agreeing with the accepted level restarts the count
                  cnt_reg <= '0;
               end else if (cnt_reg == DB_LAST) begin
                  deb_reg   <= s2_reg;
                  cnt_reg   <= '0;
                  // old level high means this is a press, not a release
                  press_reg <= deb_reg;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         end

         assign press[gi] = press_reg;
      end
   endgenerate

   logic sw_p, ad_p, de_p;
   logic held_add, held_ded;
   logic single_add, single_ded;

   assign sw_p       = press[0];
   assign ad_p       = press[1];
   assign de_p       = press[2];
   assign held_add   = ~g_btn[1].deb_reg;
   assign held_ded   = ~g_btn[2].deb_reg;
   assign single_add = held_add & ~held_ded;
   assign single_ded = held_ded & ~held_add;

   mode_t           state_reg;
   mode_t           state_next;
   logic            run_en_reg;
   logic            inc_reg;
   logic            dec_reg;
   logic            blink_reg;
   logic            timeout_reg;
   logic [TO_W-1:0] to_cnt_reg;
   logic [RP_W-1:0] rep_cnt_reg;
   logic            rep_active_reg;
   logic            rep_dir_reg;      // 0 = add, 1 = deduct
   logic            rep_fast_reg;     // past the initial delay, now at the repeat rate
   logic [BL_W-1:0] blink_cnt_reg;

   logic [1:0] mode_inc;
   logic       in_set;
   logic       fire_to;
   logic       to_clear;
   logic       strobe_ok;
   logic       rep_match;
   logic       rep_hit;
   logic       inc_next;
   logic       dec_next;

   assign mode_inc = state_reg + 2'd1;

   // Next mode, timeout decision and strobe selection.
   always_comb begin
      in_set    = (state_reg != IDLE);
      // a press or a held add/deduct counts as activity and defers the timeout
      fire_to   = in_set && !sw_p && !ad_p && !de_p && !held_add && !held_ded &&
                  (to_cnt_reg == TO_LAST);
      to_clear  = !in_set || sw_p || ad_p || de_p || held_add || held_ded || fire_to;
      strobe_ok = in_set && !sw_p && !fire_to;
      rep_match = rep_active_reg && (rep_dir_reg ? single_ded : single_add);
      rep_hit   = rep_match && (rep_cnt_reg == (rep_fast_reg ? RATE_LAST : DLY_LAST));

      state_next = state_reg;
      if (sw_p) begin
         state_next = mode_t'(mode_inc);
      end else if (fire_to) begin
         state_next = IDLE;
      end

      inc_next = 1'b0;
      dec_next = 1'b0;
      if (strobe_ok) begin
         if (ad_p ^ de_p) begin
            inc_next = ad_p;
            dec_next = de_p;
         end else if (!ad_p && !de_p && rep_hit) begin
            inc_next = ~rep_dir_reg;
            dec_next = rep_dir_reg;
         end
      end
   end

   // Mode state machine with registered outputs, timeout, auto-repeat and blink.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         run_en_reg     <= 1'b1;
         inc_reg        <= 1'b0;
         dec_reg        <= 1'b0;
         blink_reg      <= 1'b0;
         timeout_reg    <= 1'b0;
         to_cnt_reg     <= '0;
         rep_cnt_reg    <= '0;
         rep_active_reg <= 1'b0;
         rep_dir_reg    <= 1'b0;
         rep_fast_reg   <= 1'b0;
         blink_cnt_reg  <= '0;
      end else begin
         state_reg   <= state_next;
         run_en_reg  <= (state_next == IDLE);
         inc_reg     <= inc_next;
         dec_reg     <= dec_next;
         timeout_reg <= fire_to;

         if (to_clear) begin
            to_cnt_reg <= '0;
         end else if (to_cnt_reg != TO_LAST) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
         end

         if (!strobe_ok) begin
            rep_active_reg <= 1'b0;
            rep_cnt_reg    <= '0;
            rep_fast_reg   <= 1'b0;
         end else if (ad_p || de_p) begin
            // arm auto-repeat only for a lone press of a lone held button
            rep_active_reg <= (ad_p ^ de_p) && (de_p ? single_ded : single_add);
            rep_dir_reg    <= de_p;
            rep_cnt_reg    <= '0;
            rep_fast_reg   <= 1'b0;
         end else if (rep_match) begin
            if (rep_hit) begin
               rep_cnt_reg  <= '0;
               rep_fast_reg <= 1'b1;
            end else begin
               rep_cnt_reg <= rep_cnt_reg + 1'b1;
            end
         end else begin
            rep_active_reg <= 1'b0;
            rep_cnt_reg    <= '0;
            rep_fast_reg   <= 1'b0;
         end

         if (state_next == IDLE) begin
            blink_reg     <= 1'b0;
            blink_cnt_reg <= '0;
         end else if ((state_next != state_reg) || inc_next || dec_next) begin
            // show the field solid right after it is selected or changed
            blink_reg     <= 1'b1;
            blink_cnt_reg <= '0;
         end else if (blink_cnt_reg == BL_LAST) begin
            blink_reg     <= ~blink_reg;
            blink_cnt_reg <= '0;
         end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
         end
      end
   end

   assign bus.mode    = state_reg;
   assign bus.run_en  = run_en_reg;
   assign bus.inc     = inc_reg;
   assign bus.dec     = dec_reg;
   assign bus.blink   = blink_reg;
   assign bus.timeout = timeout_reg;

endmodule
